// File: rtl/ov7670_stream_gen_if.sv
// rtl/ov7670_stream_gen_if.sv - OV7670 camera-side pixel bus (pclk/href/vsync/data)
interface ov7670_stream_gen_if;
    logic       pclk;
    logic       href;
    logic       vsync;
    logic [7:0] data;

    modport master (output pclk, href, vsync, data);
    modport slave  (input  pclk, href, vsync, data);
endinterface

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - synthetic OV7670 RGB565 frame source with test patterns
// Every output register updates only on the clk edge where pclk falls.
module ov7670_stream_gen #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int H_BLANK    = 16,
    parameter int V_SYNC     = 3,
    parameter int V_BACK     = 2,
    parameter int V_FRONT    = 2,
    parameter int PCLK_DIV   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 pattern_sel,
    input  logic [15:0]                solid_rgb,
    ov7670_stream_gen_if.master        cam,
    output logic                       frame_done,
    output logic [7:0]                 frame_cnt
);

    localparam int LINE     = 2 * IMG_WIDTH + H_BLANK;
    localparam int COL_W    = $clog2(LINE + 1);
    localparam int MAX_A    = (V_SYNC > IMG_HEIGHT) ? V_SYNC : IMG_HEIGHT;
    localparam int MAX_B    = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int MAX_ROWS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int ROW_W    = $clog2(MAX_ROWS + 1);
    localparam int DIV_W    = $clog2(PCLK_DIV + 1);
    localparam int BAR_W    = $clog2(IMG_WIDTH / 8 + 1);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE - 1);
    localparam logic [COL_W-1:0] ACT_BYTES = COL_W'(2 * IMG_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PCLK_DIV - 1);
    localparam logic [BAR_W-1:0] BAR_LAST  = BAR_W'(IMG_WIDTH / 8 - 1);
    localparam logic [ROW_W-1:0] VS_LAST   = ROW_W'(V_SYNC - 1);
    localparam logic [ROW_W-1:0] BK_LAST   = ROW_W'((V_BACK > 0) ? V_BACK - 1 : 0);
    localparam logic [ROW_W-1:0] ACT_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] FR_LAST   = ROW_W'((V_FRONT > 0) ? V_FRONT - 1 : 0);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_BACK   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_FRONT  = 3'd4;

    // Zero-length blanking states are skipped entirely.
    localparam logic [2:0] AFTER_VSYNC = (V_BACK > 0) ? ST_BACK : ST_ACTIVE;
    localparam bit         HAS_FRONT   = (V_FRONT > 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pclk_q, pclk_d;
    logic [2:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [BAR_W-1:0] bar_pos_q, bar_pos_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [1:0]       pat_q, pat_d;
    logic [15:0]      rgb_q, rgb_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             done_q, done_d;
    logic             href_q, href_d;
    logic             vsync_q, vsync_d;
    logic [7:0]       data_q, data_d;

    logic             fall;
    logic             frame_end;
    logic             start;
    logic [ROW_W-1:0] row_last;
    logic [4:0]       px_x;
    logic [5:0]       px_y;
    logic [15:0]      bar_rgb;
    logic [15:0]      pix;

    always_comb begin
        div_d  = div_q + 1'b1;
        pclk_d = pclk_q;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            pclk_d = ~pclk_q;
        end
    end

    assign fall = pclk_q && (div_q == DIV_LAST);

    always_comb begin
        case (state_q)
            ST_VSYNC:  row_last = VS_LAST;
            ST_BACK:   row_last = BK_LAST;
            ST_ACTIVE: row_last = ACT_LAST;
            default:   row_last = FR_LAST;
        endcase
    end

    // Position (state, row, col) names the byte period being presented on the bus.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        bar_pos_d   = bar_pos_q;
        bar_idx_d   = bar_idx_q;
        pat_d       = pat_q;
        rgb_d       = rgb_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        frame_end   = 1'b0;
        start       = 1'b0;
        if (fall) begin
            if (state_q == ST_IDLE) begin
                start = enable;
            end else if (col_q != COL_LAST) begin
                col_d = col_q + 1'b1;
                if (col_q[0]) begin
                    if (bar_pos_q == BAR_LAST) begin
                        bar_pos_d = '0;
                        bar_idx_d = bar_idx_q + 1'b1;
                    end else begin
                        bar_pos_d = bar_pos_q + 1'b1;
                    end
                end
            end else begin
                col_d     = '0;
                bar_pos_d = '0;
                bar_idx_d = '0;
                if (row_q != row_last) begin
                    row_d = row_q + 1'b1;
                end else begin
                    row_d = '0;
                    case (state_q)
                        ST_VSYNC:  state_d = AFTER_VSYNC;
                        ST_BACK:   state_d = ST_ACTIVE;
                        ST_ACTIVE: begin
                            if (HAS_FRONT) state_d = ST_FRONT;
                            else           frame_end = 1'b1;
                        end
                        default:   frame_end = 1'b1;
                    endcase
                end
            end
            if (frame_end) begin
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = ST_IDLE;
                start       = enable;
            end
            if (start) begin
                state_d   = ST_VSYNC;
                row_d     = '0;
                col_d     = '0;
                bar_pos_d = '0;
                bar_idx_d = '0;
                pat_d     = pattern_sel;
                rgb_d     = solid_rgb;
            end
        end
    end

    always_comb begin
        px_x = 5'(col_d >> 1);
        px_y = 6'(row_d);
        case (bar_idx_d)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase
        case (pat_d)
            2'd0:    pix = rgb_d;
            2'd1:    pix = bar_rgb;
            2'd2:    pix = {px_x, px_y, frame_cnt_q[4:0]};
            default: pix = (px_x[3] ^ px_y[3]) ? 16'hFFFF : 16'h0000;
        endcase
        href_d  = href_q;
        vsync_d = vsync_q;
        data_d  = data_q;
        if (fall) begin
            href_d  = (state_d == ST_ACTIVE) && (col_d < ACT_BYTES);
            vsync_d = (state_d == ST_VSYNC);
            data_d  = !href_d ? 8'h00 : (col_d[0] ? pix[7:0] : pix[15:8]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            pclk_q      <= 1'b0;
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            bar_pos_q   <= '0;
            bar_idx_q   <= '0;
            pat_q       <= '0;
            rgb_q       <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            div_q       <= div_d;
            pclk_q      <= pclk_d;
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            bar_pos_q   <= bar_pos_d;
            bar_idx_q   <= bar_idx_d;
            pat_q       <= pat_d;
            rgb_q       <= rgb_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            href_q      <= href_d;
            vsync_q     <= vsync_d;
            data_q      <= data_d;
        end
    end

    assign cam.pclk   = pclk_q;
    assign cam.href   = href_q;
    assign cam.vsync  = vsync_q;
    assign cam.data   = data_q;
    assign frame_done = done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb/tb_ov7670_stream_gen.sv - directed/randomized bench for ov7670_stream_gen
module tb_ov7670_stream_gen;

    localparam int AW = 8,  AH = 2, AHB = 2, AVS = 1, AVB = 1, AVF = 1, ADIV = 1;
    localparam int BW = 16, BH = 3, BHB = 4, BVS = 2, BVB = 0, BVF = 0, BDIV = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b;
    logic [1:0]  pat_a, pat_b;
    logic [15:0] rgb_a, rgb_b;
    logic        done_a, done_b;
    logic [7:0]  cnt_a, cnt_b;

    int n_vec = 0;
    int n_bad = 0;
    int done_n_a = 0;
    int done_n_b = 0;
    int snap_a = 0;
    int snap_b = 0;

    ov7670_stream_gen_if ifa ();
    ov7670_stream_gen_if ifb ();

    always #5 clk = ~clk;

    ov7670_stream_gen #(
        .IMG_WIDTH(AW), .IMG_HEIGHT(AH), .H_BLANK(AHB), .V_SYNC(AVS),
        .V_BACK(AVB), .V_FRONT(AVF), .PCLK_DIV(ADIV)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .pattern_sel(pat_a),
        .solid_rgb(rgb_a), .cam(ifa), .frame_done(done_a), .frame_cnt(cnt_a)
    );

    ov7670_stream_gen #(
        .IMG_WIDTH(BW), .IMG_HEIGHT(BH), .H_BLANK(BHB), .V_SYNC(BVS),
        .V_BACK(BVB), .V_FRONT(BVF), .PCLK_DIV(BDIV)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .pattern_sel(pat_b),
        .solid_rgb(rgb_b), .cam(ifb), .frame_done(done_b), .frame_cnt(cnt_b)
    );

    always @(posedge clk) begin
        #1;
        if (done_a === 1'b1) done_n_a++;
        if (done_b === 1'b1) done_n_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] obs_of(input bit d);
        return d ? {cnt_b, ifb.vsync, ifb.href, ifb.data} : {cnt_a, ifa.vsync, ifa.href, ifa.data};
    endfunction

    function automatic int frame_len(input bit d);
        return d ? (2 * BW + BHB) * (BVS + BVB + BH + BVF) : (2 * AW + AHB) * (AVS + AVB + AH + AVF);
    endfunction

    // Expected {frame_cnt, vsync, href, data} for byte period k of a frame.
    function automatic logic [17:0] model(input bit d, input int k, input logic [1:0] pat,
                                          input logic [15:0] rgb, input logic [7:0] fc);
        int w, h, hb, vsn, vb, l, line, c, x, y;
        logic vs, hr;
        logic [15:0] xv, yv, pix;
        logic [7:0] byt;
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        w = d ? BW : AW;   h = d ? BH : AH;   hb = d ? BHB : AHB;
        vsn = d ? BVS : AVS;   vb = d ? BVB : AVB;
        l = 2 * w + hb;
        line = k / l;   c = k % l;   x = c / 2;   y = line - vsn - vb;
        vs = (line < vsn);
        hr = (y >= 0) && (y < h) && (c < 2 * w);
        xv = 16'(x);   yv = 16'(y);
        case (pat)
            2'd0:    pix = rgb;
            2'd1:    pix = bars[(x / (w / 8)) % 8];
            2'd2:    pix = {xv[4:0], yv[5:0], fc[4:0]};
            default: pix = (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
        endcase
        byt = !hr ? 8'h00 : ((c % 2 == 1) ? pix[7:0] : pix[15:8]);
        return {fc, vs, hr, byt};
    endfunction

    task automatic next_rise(input bit d);
        logic p, c;
        bit got;
        got = 1'b0;
        p = d ? ifb.pclk : ifa.pclk;
        for (int i = 0; i < 8 * BDIV && !got; i++) begin
            @(negedge clk);
            c = d ? ifb.pclk : ifa.pclk;
            if (c && !p) got = 1'b1;
            p = c;
        end
        if (!got) chk("pclk_rise", {31'd0, got}, 32'd1);
    endtask

    task automatic capture(input bit d, input int stop_k, input logic [1:0] pat,
                           input logic [15:0] rgb, input logic [7:0] fc, input int mid_k,
                           input logic [1:0] npat, input logic [15:0] nrgb, input logic nen);
        int tries, div;
        logic vs;
        div = d ? BDIV : ADIV;
        if (d) snap_b = done_n_b; else snap_a = done_n_a;
        tries = 0;
        vs = 1'b0;
        while (!vs && tries < 4) begin
            next_rise(d);
            vs = d ? ifb.vsync : ifa.vsync;
            tries++;
        end
        chk("frame_start", {31'd0, vs}, 32'd1);
        for (int k = 0; k < stop_k; k++) begin
            if (k > 0) next_rise(d);
            chk($sformatf("bus%0d_k%0d", d, k), {14'd0, obs_of(d)}, {14'd0, model(d, k, pat, rgb, fc)});
            if (k == mid_k) begin
                if (d) begin pat_b = npat; rgb_b = nrgb; en_b = nen; end
                else   begin pat_a = npat; rgb_a = nrgb; en_a = nen; end
            end
        end
        if (stop_k == frame_len(d)) begin
            repeat (div) @(negedge clk);
            chk("done_pulse", {31'd0, d ? done_b : done_a}, 32'd1);
            chk("done_cnt", {24'd0, d ? cnt_b : cnt_a}, {24'd0, fc + 8'd1});
        end
    endtask

    initial begin
        logic [15:0] r1, r2, r3;
        int vs_seen, s;
        en_a = 1'b0; en_b = 1'b0; pat_a = 2'd0; pat_b = 2'd0;
        rgb_a = 16'h0000; rgb_b = 16'h0000; reset = 1'b0;

        // reset and idle divider
        repeat (5) @(negedge clk);
        chk("rst_a", {12'd0, ifa.pclk, done_a, obs_of(1'b0)}, 32'd0);
        chk("rst_b", {12'd0, ifb.pclk, done_b, obs_of(1'b1)}, 32'd0);
        reset = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            chk("idle_a", {12'd0, ifa.pclk, done_a, obs_of(1'b0)}, {12'd0, 1'((n / ADIV) % 2), 1'b0, 18'd0});
            chk("idle_b", {12'd0, ifb.pclk, done_b, obs_of(1'b1)}, {12'd0, 1'((n / BDIV) % 2), 1'b0, 18'd0});
        end

        // solid frame; rgb change mid-frame only lands on the next frame
        r1 = 16'($urandom_range(1, 65535));
        r2 = 16'($urandom);
        pat_a = 2'd0; rgb_a = 16'hF81F; en_a = 1'b1;
        capture(1'b0, frame_len(1'b0), 2'd0, 16'hF81F, 8'd0, 50, 2'd0, r1, 1'b1);

        // pattern switch and enable drop during ACTIVE
        capture(1'b0, frame_len(1'b0), 2'd0, r1, 8'd1, 40, 2'd3, r2, 1'b0);
        vs_seen = 0;
        repeat (3 * 90 * 2) begin
            @(negedge clk);
            if (ifa.vsync) vs_seen++;
        end
        chk("no_vsync", 32'(vs_seen), 32'd0);
        chk("done_once", 32'(done_n_a - snap_a), 32'd1);

        // color bars then checkerboard on the wide instance
        pat_b = 2'd1; rgb_b = 16'($urandom); en_b = 1'b1;
        capture(1'b1, frame_len(1'b1), 2'd1, rgb_b, 8'd0, 5, 2'd3, 16'h0000, 1'b1);
        capture(1'b1, frame_len(1'b1), 2'd3, 16'h0000, 8'd1, 5, 2'd0, 16'h0000, 1'b0);

        // asynchronous reset during active line 1
        pat_a = 2'd0; rgb_a = 16'hA5C3; en_a = 1'b1;
        capture(1'b0, (AVS + AVB + 1) * (2 * AW + AHB) + 5, 2'd0, 16'hA5C3, 8'd2, -1, 2'd0, 16'h0000, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst", {12'd0, ifa.pclk, done_a, obs_of(1'b0)}, 32'd0);
        r3 = 16'($urandom_range(1, 65535));
        rgb_a = r3;
        @(negedge clk);
        reset = 1'b1;
        capture(1'b0, frame_len(1'b0), 2'd0, r3, 8'd0, 10, 2'd2, 16'h0000, 1'b1);

        // 257 back-to-back gradient frames across the counter wrap
        s = done_n_a;
        for (int i = 0; i < 257; i++) begin
            capture(1'b0, frame_len(1'b0), 2'd2, 16'h0000, 8'(1 + i),
                    (i == 256) ? 10 : -1, 2'd2, 16'h0000, (i == 256) ? 1'b0 : 1'b1);
        end
        repeat (4) @(negedge clk);
        chk("wrap_dones", 32'(done_n_a - s), 32'd257);
        chk("final_cnt", {24'd0, cnt_a}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ov7670_stream_gen.md
Name: ov7670_stream_gen

Overview:
- Synthetic OV7670 sensor: the transmit end of the camera capture interface.
- Drives pclk/href/vsync/data[7:0] with OV7670 RGB565 timing, scaled to IMG_WIDTH x IMG_HEIGHT.
- Feeds the OV7670_Controller capture path in simulation and in on-board loopback, so frame buffers, color detection and overlay can be exercised without a physical camera.
- Generates selectable test patterns and reports frame completion.

Parameters:
IMG_WIDTH, 160, active pixels per line (multiple of 8)
IMG_HEIGHT, 120, active lines per frame
H_BLANK, 16, pclk periods with href low after each line's active bytes
V_SYNC, 3, line-times with vsync high at frame start
V_BACK, 2, blank line-times between vsync fall and first active line
V_FRONT, 2, blank line-times after last active line
PCLK_DIV, 2, clk cycles per pclk half-period (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  permits new frames; sampled only at frame start
pattern_sel  in  2  0 solid, 1 color bars, 2 gradient, 3 checkerboard
solid_rgb  in  16  RGB565 color for pattern 0
pclk  out  1  generated pixel clock
href  out  1  line-valid, high during active bytes
vsync  out  1  frame sync, active high
data  out  8  RGB565 byte stream
frame_done  out  1  one-clk pulse when a frame's V_FRONT period ends
frame_cnt  out  8  completed-frame count, wraps 255->0

Behaviour:
- Reset (reset low, async) values: pclk=0, href=0, vsync=0, data=0, frame_done=0, frame_cnt=0, FSM=IDLE, all counters 0.
- pclk divider:
  - pclk high for PCLK_DIV clks, then low for PCLK_DIV clks, free-running after reset release.
  - Starts low.
  - The first rising edge occurs PCLK_DIV clks after release.
- Output timing:
  - href, vsync and data are registered and change only on the clk edge where pclk goes 1->0.
  - Receiver samples them on pclk rising edges with a half-period of setup.
- Line-time L = 2*IMG_WIDTH + H_BLANK pclk periods.
- Line structure: 2*IMG_WIDTH periods with href=1, then H_BLANK periods with href=0.
- data=0 whenever href=0.
- FSM (advances per pclk period):
  - IDLE: outputs low. Leaves at a pclk falling edge with enable=1, going to VSYNC. pattern_sel and solid_rgb are latched into shadow registers on this transition.
  - VSYNC: vsync=1 for V_SYNC*L periods, then BACK.
  - BACK: V_BACK*L periods, then ACTIVE.
  - ACTIVE: IMG_HEIGHT lines. y counts 0..IMG_HEIGHT-1, x counts 0..IMG_WIDTH-1. After the last line's H_BLANK, go to FRONT.
  - FRONT: V_FRONT*L periods. At the end, frame_done pulses one clk and frame_cnt increments. Then VSYNC if enable=1 (re-latching shadows), else IDLE.
- Byte order per pixel: first byte = pix[15:8], second = pix[7:0].
- Patterns (x, y = active pixel coordinates; shadow values used for the whole frame):
  - 0: pix = solid_rgb.
  - 1: 8 vertical bars, each IMG_WIDTH/8 wide. Bar index comes from a bar counter, with no divider. Order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2: pix = {x[4:0], y[5:0], frame_cnt[4:0]}.
  - 3: pix = FFFF if x[3]^y[3] else 0000.
- Boundary rules:
  - enable falling mid-frame: the frame completes normally; no new frame starts.
  - pattern_sel or solid_rgb changing mid-frame: no effect until the next frame start.
  - Reset asserted mid-frame: all outputs go to reset values immediately (async). The next frame restarts in VSYNC with fresh latches.
  - frame_cnt 255 + 1 -> 0.
  - V_BACK or V_FRONT = 0: the state is skipped (zero periods).
- Throughput: one byte per pclk period, no stalls, no backpressure.

Test Plan:
1. Reset/idle:
   - Stimulus: hold reset low 5 clks, release with enable=0, run 100 clks.
   - Required: pclk toggles every PCLK_DIV clks; href=vsync=data=0; frame_done never pulses.
2. Solid frame:
   - Stimulus: IMG_WIDTH=8, IMG_HEIGHT=2, H_BLANK=2, V_SYNC=1, V_BACK=1, V_FRONT=1, PCLK_DIV=1; solid_rgb=0xF81F, enable=1.
   - Required:
     - vsync high for exactly 18 pclk rises.
     - Each line: 16 href-high rises with bytes alternating F8,1F, then 2 rises with href=0, data=0.
     - frame_done after 90 pclk periods; frame_cnt=1.
3. Color bars:
   - Stimulus: IMG_WIDTH=16, pattern_sel=1.
   - Required: pixel pairs are FFFF,FFFF,FFE0,FFE0,07FF,...,0000,0000 on every active line.
4. Mid-frame changes:
   - Stimulus: switch pattern_sel 0->3 and drop enable during ACTIVE of frame 1.
   - Required: frame 1 stays solid to the end; frame_done pulses once; FSM returns to IDLE with no second vsync.
5. Reset mid-frame:
   - Stimulus: assert reset during ACTIVE line 1, then release.
   - Required: href, vsync, data, frame_cnt go to 0 within the same clk without waiting for an edge; the next frame begins with the full V_SYNC period.
6. Counter wrap:
   - Stimulus: run 257 back-to-back frames with pattern_sel=2.
   - Required: frame_cnt reads 255 then 0 then 1; the B field of the gradient tracks frame_cnt[4:0].
